dm_arbiter: RTL and testbench

- Two-requester arbiter in front of the single-port data memory.
- Port 0 is the CPU MEM stage: highest priority, combinational read return.
- Port 1 is the debug/DMA loader: lower priority, registered read return, starvation-protected.
- Misaligned accesses are rejected without touching memory, and an error response is returned.

---
 rtl/dm_arbiter_pkg.sv | 9 +
 rtl/dm_arbiter_if.sv | 30 +++
 rtl/dm_align_chk.sv | 11 +
 rtl/dm_arbiter.sv | 58 +++++
 tb/tb_dm_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: data memory access type codes and arbiter state encodings
package dm_arbiter_pkg;
  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;
  typedef enum logic {OWN0 = 1'b0, FORCE1 = 1'b1} arb_state_e;
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: CPU port, loader port and data memory signals around the arbiter
interface dm_arbiter_if #(parameter int ADDR_W = 32);
  logic              p0_req, p0_we, p0_ready, p0_err;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_wdata, p0_rdata;
  logic [2:0]        p0_type;
  logic              p1_req, p1_we, p1_ready, p1_rvalid, p1_err;
  logic [ADDR_W-1:0] p1_addr;
  logic [31:0]       p1_wdata, p1_rdata;
  logic [2:0]        p1_type;
  logic              dm_wr, dm_rd;
  logic [31:0]       dm_addr, dm_wdata, dm_rdata;
  logic [2:0]        dm_type;
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_type,
    output p0_ready, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_type,
    output p1_ready, p1_rvalid, p1_rdata, p1_err,
    output dm_wr, dm_rd, dm_addr, dm_wdata, dm_type,
    input  dm_rdata
  );
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_type,
    input  p0_ready, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_type,
    input  p1_ready, p1_rvalid, p1_rdata, p1_err,
    input  dm_wr, dm_rd, dm_addr, dm_wdata, dm_type,
    output dm_rdata
  );
endinterface

// File: rtl/dm_align_chk.sv
// dm_align_chk: flags an access whose address is not aligned to its size
module dm_align_chk
  import dm_arbiter_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] acc_type,
  output logic       misaligned
);
  assign misaligned = (acc_type == DM_BYTE || acc_type == DM_BYTE_U) ? 1'b0 :
                      (acc_type == DM_HALF || acc_type == DM_HALF_U) ? addr_lo[0] : |addr_lo;
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: CPU-priority data memory arbiter with a starvation-protected loader port
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 32
)(
  input logic         clk,
  input logic         rstn,
  dm_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             mis0, mis1, gnt0, gnt1, sel_we, sel_mis, go;
  dm_align_chk u_chk0 (.addr_lo(bus.p0_addr[1:0]), .acc_type(bus.p0_type), .misaligned(mis0));
  dm_align_chk u_chk1 (.addr_lo(bus.p1_addr[1:0]), .acc_type(bus.p1_type), .misaligned(mis1));
  // single grant per cycle; the loader wins only when owed or when the CPU is idle
  always_comb begin
    gnt1         = rstn & bus.p1_req & ((state == FORCE1) | ~bus.p0_req);
    gnt0         = rstn & bus.p0_req & ~gnt1;
    wait_cnt_nxt = (bus.p1_req & ~gnt1) ? wait_cnt + 1'b1 : '0;
    state_nxt    = (state == OWN0 && wait_cnt == CNT_W'(MAX_WAIT - 1) && bus.p1_req && !gnt1) ? FORCE1 : OWN0;
  end
  // route the granted port to memory; misaligned accesses complete without touching it
  always_comb begin
    sel_we       = gnt1 ? bus.p1_we : bus.p0_we;
    sel_mis      = gnt1 ? mis1 : mis0;
    go           = (gnt0 | gnt1) & ~sel_mis;
    bus.dm_wr    = go & sel_we;
    bus.dm_rd    = go & ~sel_we;
    bus.dm_addr  = go ? 32'(gnt1 ? bus.p1_addr : bus.p0_addr) : '0;
    bus.dm_wdata = go ? (gnt1 ? bus.p1_wdata : bus.p0_wdata) : '0;
    bus.dm_type  = go ? (gnt1 ? bus.p1_type : bus.p0_type) : '0;
    bus.p0_ready = gnt0;
    bus.p0_err   = gnt0 & mis0;
    bus.p0_rdata = (gnt0 & ~mis0 & ~bus.p0_we) ? bus.dm_rdata : '0;
    bus.p1_ready = gnt1;
  end
  // ownership, starvation count and the registered loader response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= OWN0;
      wait_cnt      <= '0;
      bus.p1_rvalid <= 1'b0;
      bus.p1_rdata  <= '0;
      bus.p1_err    <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_cnt_nxt;
      bus.p1_rvalid <= gnt1;
      if (gnt1) begin
        bus.p1_err   <= mis1;
        bus.p1_rdata <= (~mis1 & ~bus.p1_we) ? bus.dm_rdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: vector table, corner sequences and randomized model check of dm_arbiter
module tb_dm_arbiter;
  localparam int MAX_WAIT = 4;
  typedef struct {
    logic        p0r, p0w;
    logic [31:0] p0a, p0d;
    logic [2:0]  p0t;
    logic        p1r, p1w;
    logic [31:0] p1a, p1d;
    logic [2:0]  p1t;
    logic        e0rdy, e0err;
    logic [31:0] e0rd;
    logic        e1rdy, e1rv;
    logic [31:0] e1rd;
    logic        e1err, ewr, erd;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [31:0] mem [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  int          denials = 0;
  logic        pend_v = 1'b0, hold_err = 1'b0;
  logic [31:0] hold_rd = 32'h0;
  logic        m_g0, m_g1, m_ok, m_gwe, m_mis0, m_mis1;
  logic [31:0] m_ga, m_gd, m_ld;
  logic [2:0]  m_gt;

  dm_arbiter_if #(.ADDR_W(32)) bus ();
  dm_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] ld_ext(logic [31:0] w, logic [1:0] a, logic [2:0] t);
    logic [31:0] s;
    s = w >> (8 * a);
    case (t)
      3'd1: return {{16{s[15]}}, s[15:0]};
      3'd2: return {16'h0, s[15:0]};
      3'd3: return {{24{s[7]}}, s[7:0]};
      3'd4: return {24'h0, s[7:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(logic [31:0] w, logic [1:0] a, logic [31:0] d, logic [2:0] t);
    logic [31:0] m;
    m = (t == 3'd1 || t == 3'd2) ? 32'h0000_FFFF : (t == 3'd3 || t == 3'd4) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    m = m << (8 * a);
    return (w & ~m) | ((d << (8 * a)) & m);
  endfunction

  function automatic bit misal(logic [31:0] a, logic [2:0] t);
    int sz;
    sz = (t == 3'd1 || t == 3'd2) ? 2 : (t == 3'd3 || t == 3'd4) ? 1 : 4;
    return (a % sz) != 0;
  endfunction

  // memory: combinational read, store committed at the clock edge
  always @(posedge clk)
    if (bus.dm_wr) mem[bus.dm_addr[7:2]] <= st_merge(mem[bus.dm_addr[7:2]], bus.dm_addr[1:0], bus.dm_wdata, bus.dm_type);
  always_comb bus.dm_rdata = ld_ext(mem[bus.dm_addr[7:2]], bus.dm_addr[1:0], bus.dm_type);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.p0_req = v.p0r; bus.p0_we = v.p0w; bus.p0_addr = v.p0a; bus.p0_wdata = v.p0d; bus.p0_type = v.p0t;
    bus.p1_req = v.p1r; bus.p1_we = v.p1w; bus.p1_addr = v.p1a; bus.p1_wdata = v.p1d; bus.p1_type = v.p1t;
  endtask

  task automatic model_reset();
    denials = 0; pend_v = 1'b0; hold_rd = 32'h0; hold_err = 1'b0;
  endtask

  // reference: the loader is owed the grant after MAX_WAIT consecutive denials
  task automatic model_eval();
    m_g1   = bus.p1_req && (denials >= MAX_WAIT || !bus.p0_req);
    m_g0   = bus.p0_req && !m_g1;
    m_mis0 = misal(bus.p0_addr, bus.p0_type);
    m_mis1 = misal(bus.p1_addr, bus.p1_type);
    m_ga   = m_g1 ? bus.p1_addr : bus.p0_addr;
    m_gd   = m_g1 ? bus.p1_wdata : bus.p0_wdata;
    m_gt   = m_g1 ? bus.p1_type : bus.p0_type;
    m_gwe  = m_g1 ? bus.p1_we : bus.p0_we;
    m_ok   = (m_g0 || m_g1) && !(m_g1 ? m_mis1 : m_mis0);
    m_ld   = ld_ext(ref_mem[m_ga[7:2]], m_ga[1:0], m_gt);
  endtask

  task automatic model_commit();
    if (m_ok && m_gwe) ref_mem[m_ga[7:2]] = st_merge(ref_mem[m_ga[7:2]], m_ga[1:0], m_gd, m_gt);
    pend_v = m_g1;
    if (m_g1) begin
      hold_rd  = (!m_mis1 && !bus.p1_we) ? m_ld : 32'h0;
      hold_err = m_mis1;
    end
    denials = (bus.p1_req && !m_g1) ? denials + 1 : 0;
  endtask

  task automatic model_check();
    chk("rnd p0_ready", bus.p0_ready, m_g0);
    chk("rnd p1_ready", bus.p1_ready, m_g1);
    chk("rnd p0_err", bus.p0_err, m_g0 && m_mis0);
    chk("rnd p0_rdata", bus.p0_rdata, (m_g0 && !m_mis0 && !bus.p0_we) ? m_ld : 32'h0);
    chk("rnd dm_wr", bus.dm_wr, m_ok && m_gwe);
    chk("rnd dm_rd", bus.dm_rd, m_ok && !m_gwe);
    if (m_ok) chk("rnd dm_addr", bus.dm_addr, m_ga);
    else if (!m_g0 && !m_g1) chk("rnd dm_addr idle", bus.dm_addr, 32'h0);
    chk("rnd p1_rvalid", bus.p1_rvalid, pend_v);
    chk("rnd p1_rdata", bus.p1_rdata, hold_rd);
    chk("rnd p1_err", bus.p1_err, hold_err);
  endtask

  task automatic tbl_check(input int i, input vec_t v);
    chk($sformatf("row%0d p0_ready", i), bus.p0_ready, v.e0rdy);
    chk($sformatf("row%0d p0_err", i), bus.p0_err, v.e0err);
    chk($sformatf("row%0d p0_rdata", i), bus.p0_rdata, v.e0rd);
    chk($sformatf("row%0d p1_ready", i), bus.p1_ready, v.e1rdy);
    chk($sformatf("row%0d p1_rvalid", i), bus.p1_rvalid, v.e1rv);
    chk($sformatf("row%0d p1_rdata", i), bus.p1_rdata, v.e1rd);
    chk($sformatf("row%0d p1_err", i), bus.p1_err, v.e1err);
    chk($sformatf("row%0d dm_wr", i), bus.dm_wr, v.ewr);
    chk($sformatf("row%0d dm_rd", i), bus.dm_rd, v.erd);
  endtask

  // one clock: drive after the edge, evaluate at the falling edge (mode 0 none, 1 table, 2 model)
  task automatic step(input vec_t v, input int mode, input int idx);
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    model_eval();
    if (mode == 1) tbl_check(idx, v);
    else if (mode == 2) model_check();
    model_commit();
  endtask

  vec_t tbl [13];
  vec_t idle, c, r;

  initial begin
    tbl[0]  = '{1,1,'h10,'hDEADBEEF,0, 0,0,0,0,0, 1,0,0,          0,0,0,0,    1,0};
    tbl[1]  = '{1,0,'h10,0,0,          0,0,0,0,0, 1,0,'hDEADBEEF, 0,0,0,0,    0,1};
    tbl[2]  = '{0,0,0,0,0, 1,1,'h10,'h80FF1234,0, 0,0,0,          1,0,0,0,    1,0};
    tbl[3]  = '{0,0,0,0,0, 1,0,'h13,0,4,          0,0,0,          1,1,0,0,    0,1};
    tbl[4]  = '{0,0,0,0,0, 0,0,0,0,0,             0,0,0,          0,1,'h80,0, 0,0};
    tbl[5]  = '{1,0,'h22,0,0,          0,0,0,0,0, 1,1,0,          0,0,'h80,0, 0,0};
    tbl[6]  = '{0,0,0,0,0, 1,1,'h21,'h5555,1,     0,0,0,          1,0,'h80,0, 0,0};
    tbl[7]  = '{0,0,0,0,0, 0,0,0,0,0,             0,0,0,          0,1,0,1,    0,0};
    tbl[8]  = '{1,0,'h12,0,1,          0,0,0,0,0, 1,0,'hFFFF80FF, 0,0,0,1,    0,1};
    tbl[9]  = '{1,0,'h11,0,3, 1,0,'h12,0,2,       1,0,'h12,       0,0,0,1,    0,1};
    tbl[10] = '{0,0,0,0,0, 1,1,'h17,'hAB,4,       0,0,0,          1,0,0,1,    1,0};
    tbl[11] = '{1,0,'h14,0,0,          0,0,0,0,0, 1,0,'hAB000000, 0,1,0,0,    0,1};
    tbl[12] = '{0,0,0,0,0, 0,0,0,0,0,             0,0,0,          0,0,0,0,    0,0};
    idle = '{default: 0};

    c = idle; c.p0r = 1'b1; c.p0a = 32'h10;
    drive(c);
    #12;
    chk("reset p0_ready", bus.p0_ready, 1'b0);
    chk("reset dm_rd", bus.dm_rd, 1'b0);
    chk("reset dm_addr", bus.dm_addr, 32'h0);
    chk("reset p1_rvalid", bus.p1_rvalid, 1'b0);
    chk("reset p1_rdata", bus.p1_rdata, 32'h0);
    chk("reset p1_err", bus.p1_err, 1'b0);
    drive(idle);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i]) step(tbl[i], 1, i);

    c = idle; c.p0r = 1'b1; c.p0a = 32'h10; c.p1r = 1'b1; c.p1a = 32'h14;
    for (int k = 0; k < 6; k++) begin
      step(c, 0, 0);
      chk($sformatf("contend c%0d p0_ready", k), bus.p0_ready, k != 4);
      chk($sformatf("contend c%0d p1_ready", k), bus.p1_ready, k == 4);
    end
    step(idle, 0, 0);

    for (int k = 0; k < 4; k++) step(c, 0, 0);
    step(idle, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(c, 0, 0);
      chk($sformatf("drop c%0d p1_ready", k), bus.p1_ready, k == 4);
    end
    step(idle, 0, 0);

    r = idle; r.p1r = 1'b1; r.p1a = 32'h10;
    step(r, 0, 0);
    chk("rst-mid grant", bus.p1_ready, 1'b1);
    @(posedge clk); #1;
    chk("rst-mid rvalid before", bus.p1_rvalid, 1'b1);
    chk("rst-mid rdata before", bus.p1_rdata, 32'h80FF1234);
    rstn = 1'b0;
    #1;
    chk("rst-mid rvalid", bus.p1_rvalid, 1'b0);
    chk("rst-mid rdata", bus.p1_rdata, 32'h0);
    chk("rst-mid p1_ready", bus.p1_ready, 1'b0);
    chk("rst-mid dm_rd", bus.dm_rd, 1'b0);
    model_reset();
    drive(idle);
    @(negedge clk);
    rstn = 1'b1;
    step(idle, 0, 0);
    chk("post-rst no rvalid", bus.p1_rvalid, 1'b0);
    step(c, 0, 0);
    chk("post-rst p0 owns", bus.p0_ready, 1'b1);
    chk("post-rst rvalid", bus.p1_rvalid, 1'b0);
    step(idle, 0, 0);

    for (int k = 0; k < 400; k++) begin
      r.p0r = ($urandom_range(0, 9) < 8);
      r.p0w = $urandom_range(0, 1);
      r.p0a = $urandom_range(0, 255);
      r.p0d = $urandom;
      r.p0t = $urandom_range(0, 7);
      r.p1r = ($urandom_range(0, 9) < 7);
      r.p1w = $urandom_range(0, 1);
      r.p1a = $urandom_range(0, 255);
      r.p1d = $urandom;
      r.p1t = $urandom_range(0, 7);
      step(r, 2, k);
    end
    step(idle, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
